// File: rtl/encoder_layer_bias_sink.sv
// encoder_layer_bias_sink: receives the bias parameter stream, packs IN_DEPTH
// beats into an on-chip buffer and serves it through a ROM-style read port
// (address0/ce0/q0, 2-cycle latency). A downstream layer can therefore swap a
// bias ROM for runtime-loaded biases without changing its read logic.
// Optional feature macro: BIAS_SINK_CHECKSUM_EN adds a running element-sum
// output `checksum` over the current load.
module encoder_layer_bias_sink #(
  parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PARALLELISM_DIM_0 = 1,
  parameter int BIAS_PARALLELISM_DIM_1 = 1,
  parameter int IN_DEPTH               = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0,
  parameter int ADDR_WIDTH             = $clog2(IN_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIAS_PRECISION_0-1:0]  data_in [BIAS_PARALLELISM_DIM_0*BIAS_PARALLELISM_DIM_1-1:0],
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  input  logic                         reload,
  output logic                         loaded,
  input  logic [ADDR_WIDTH-1:0]        address0,
  input  logic                         ce0,
  output logic [BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0*BIAS_PARALLELISM_DIM_1-1:0] q0
`ifdef BIAS_SINK_CHECKSUM_EN
  ,
  output logic [BIAS_PRECISION_0+$clog2(BIAS_TENSOR_SIZE_DIM_0)-1:0] checksum
`endif
);

  localparam int P     = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1;
  localparam int W     = BIAS_PRECISION_0 * P;
  // Buffer index width; the array is rounded up to a power of two so a
  // truncated index can never fall outside it.
  localparam int MAW   = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int NWORD = 1 << MAW;

  typedef enum logic {FILL, FULL} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_loaded;
  logic [W-1:0]          r_mem [NWORD];
  logic [W-1:0]          r_stage0;
  logic [W-1:0]          r_q0;

  logic [W-1:0]          w_beat;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_addr_oob;

  // Pack the element array: element j lands at bits [PREC*j +: PREC].
  always_comb begin
    w_beat = '0;
    for (int j = 0; j < P; j++)
      w_beat[BIAS_PRECISION_0*j +: BIAS_PRECISION_0] = data_in[j];
  end

  // Ready depends only on state and reload, so reload wins over a beat.
  assign data_in_ready = (r_state == FILL) && !reload;
  assign w_accept      = data_in_valid && data_in_ready;
  assign w_last        = (r_wr_ptr == ADDR_WIDTH'(IN_DEPTH - 1));
  assign w_addr_oob    = (address0 >= ADDR_WIDTH'(IN_DEPTH));
  assign loaded        = r_loaded;
  assign q0            = r_q0;

  // Load FSM: FILL counts beats into the buffer, FULL holds off the stream.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      r_state  <= FILL;
      r_wr_ptr <= '0;
      r_loaded <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_state  <= FULL;
        r_wr_ptr <= '0;
        r_loaded <= 1'b1;
      end else begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  // Buffer write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_accept && !rst)
      r_mem[r_wr_ptr[MAW-1:0]] <= w_beat;
  end

  // Two-stage read pipeline gated by ce0; read-first against a same-cycle
  // write because the array is sampled before the write edge lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage0 <= '0;
      r_q0     <= '0;
    end else if (ce0) begin
      r_stage0 <= w_addr_oob ? '0 : r_mem[address0[MAW-1:0]];
      r_q0     <= r_stage0;
    end
  end

`ifdef BIAS_SINK_CHECKSUM_EN
  localparam int CW = BIAS_PRECISION_0 + $clog2(BIAS_TENSOR_SIZE_DIM_0);

  logic [CW-1:0] r_checksum;
  logic [CW-1:0] w_beat_sum;

  // Modular sum of the elements in the current beat.
  always_comb begin
    w_beat_sum = '0;
    for (int j = 0; j < P; j++)
      w_beat_sum = w_beat_sum + CW'(data_in[j]);
  end

  // Running checksum of the current load, cleared with the load itself.
  always_ff @(posedge clk) begin
    if (rst || reload)
      r_checksum <= '0;
    else if (w_accept)
      r_checksum <= r_checksum + w_beat_sum;
  end

  assign checksum = r_checksum;
`endif

endmodule
